// File: rtl/ooo_types.sv
// Shared types for the out-of-order front end.
//  - PHYS_REG_BITS / ROB_BITS : widths of physical register and ROB tag fields
//  - FU_ALU / FU_BR / FU_LSU  : fu_type encodings (2'b11 is reserved and runs on the ALU)
//  - renamed_instr_t          : payload handed from rename to dispatch
//  - rs_sel_e / route_fu()    : which reservation station an fu_type goes to
package ooo_types;

  localparam int PHYS_REG_BITS = 7;
  localparam int ROB_BITS      = 5;

  localparam logic [1:0] FU_ALU = 2'b00;
  localparam logic [1:0] FU_BR  = 2'b01;
  localparam logic [1:0] FU_LSU = 2'b10;

  typedef struct packed {
    logic [31:0]              pc;
    logic [ROB_BITS-1:0]      rob_tag;
    logic [1:0]               fu_type;
    logic                     reg_write;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
  } renamed_instr_t;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_BR  = 2'd1,
    RS_LSU = 2'd2
  } rs_sel_e;

  // The reserved encoding falls through to the ALU station.
  function automatic rs_sel_e route_fu(input logic [1:0] fu_type);
    rs_sel_e sel;
    case (fu_type)
      FU_BR:   sel = RS_BR;
      FU_LSU:  sel = RS_LSU;
      default: sel = RS_ALU;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dispatch_phys_busy_table.sv
// Physical-register busy table with writeback bypass.
// One bit per physical register, 1 = value still pending.
// Ports:
//  clk, rst           clock, synchronous active-high reset (all registers ready)
//  set_en, set_idx    mark set_idx pending (ignored for p0)
//  clr_en, clr_idx    writeback: mark clr_idx ready
//  rd_idx1, rd_idx2   lookup indices
//  rdy1, rdy2         lookup results, including a same-cycle writeback bypass
module phys_busy_table
  import ooo_types::*;
#(
  parameter int NUM_PHYS_REGS = 2**PHYS_REG_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [PHYS_REG_BITS-1:0] set_idx,
  input  logic                     clr_en,
  input  logic [PHYS_REG_BITS-1:0] clr_idx,
  input  logic [PHYS_REG_BITS-1:0] rd_idx1,
  input  logic [PHYS_REG_BITS-1:0] rd_idx2,
  output logic                     rdy1,
  output logic                     rdy2
);

  logic [NUM_PHYS_REGS-1:0] busy_q;
  logic [NUM_PHYS_REGS-1:0] busy_d;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; without it a missed branch infers a latch.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    // Set after clear so a register reallocated in the same cycle as its
    // stale writeback stays pending.
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: this table is a flop array, not a RAM, so it is reset in full;
  // every register must read as ready out of reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all
    // flops sample the pre-edge values regardless of statement order.
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // The bypass lets a source waiting on this cycle's writeback issue now.
  always_comb begin
    rdy1 = (rd_idx1 == '0) | ~busy_q[rd_idx1] | (clr_en & (clr_idx == rd_idx1));
    rdy2 = (rd_idx2 == '0) | ~busy_q[rd_idx2] | (clr_en & (clr_idx == rd_idx2));
  end

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: sits after rename, holds one instruction and sends it to the
// ROB and one reservation station in the same cycle.
// Ports:
//  clk, rst                 clock, synchronous active-high reset
//  valid_in / ready_out     handshake with rename; renamed_instr is the payload
//  disp_instr               held payload, shared by the ROB and all stations
//  src1_ready, src2_ready   operand availability of the held instruction
//  rob_valid / rob_ready    ROB allocation at disp_instr.rob_tag
//  rs_{alu,br,lsu}_valid    write strobe to the selected station
//  rs_{alu,br,lsu}_ready    station has a free slot
//  wb_valid, wb_prd         writeback broadcast (clears busy, bypasses lookup)
//  mispredict               squash: drop the held instruction, accept nothing
module dispatch
  import ooo_types::*;
#(
  parameter int NUM_PHYS_REGS = 2**PHYS_REG_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  renamed_instr_t           renamed_instr,
  output renamed_instr_t           disp_instr,
  output logic                     src1_ready,
  output logic                     src2_ready,
  output logic                     rob_valid,
  input  logic                     rob_ready,
  output logic                     rs_alu_valid,
  input  logic                     rs_alu_ready,
  output logic                     rs_br_valid,
  input  logic                     rs_br_ready,
  output logic                     rs_lsu_valid,
  input  logic                     rs_lsu_ready,
  input  logic                     wb_valid,
  input  logic [PHYS_REG_BITS-1:0] wb_prd,
  input  logic                     mispredict
);

  logic           hold_valid_q, hold_valid_d;
  renamed_instr_t hold_instr_q, hold_instr_d;

  rs_sel_e sel;
  logic    tgt_ready;
  logic    fire;
  logic    accept;

  always_comb begin
    sel = route_fu(hold_instr_q.fu_type);

    case (sel)
      RS_BR:   tgt_ready = rs_br_ready;
      RS_LSU:  tgt_ready = rs_lsu_ready;
      default: tgt_ready = rs_alu_ready;
    endcase

    // ROB and station are written together or not at all. No valid looks at
    // its own station's ready in a way that feeds back into that ready.
    fire      = hold_valid_q & rob_ready & tgt_ready & ~mispredict;
    // The register may refill in the same cycle its occupant leaves.
    ready_out = ~mispredict & (~hold_valid_q | fire);
    accept    = valid_in & ready_out;

    rob_valid    = fire;
    rs_alu_valid = fire & (sel == RS_ALU);
    rs_br_valid  = fire & (sel == RS_BR);
    rs_lsu_valid = fire & (sel == RS_LSU);

    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    if (mispredict) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
      hold_instr_d = renamed_instr;
    end else if (fire) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign disp_instr = hold_instr_q;

  // A squashed destination is not unmarked; it is re-set when rename hands
  // it out again, and its eventual writeback still clears it.
  phys_busy_table #(
    .NUM_PHYS_REGS (NUM_PHYS_REGS)
  ) u_busy (
    .clk     (clk),
    .rst     (rst),
    .set_en  (fire & hold_instr_q.reg_write),
    .set_idx (hold_instr_q.prd),
    .clr_en  (wb_valid),
    .clr_idx (wb_prd),
    .rd_idx1 (hold_instr_q.prs1),
    .rd_idx2 (hold_instr_q.prs2),
    .rdy1    (src1_ready),
    .rdy2    (src2_ready)
  );

endmodule

// File: tb/tb_dispatch.sv
module tb_dispatch;
  import ooo_types::*;

  logic clk = 1'b0;
  logic rst;
  logic valid_in, ready_out;
  renamed_instr_t renamed_instr, disp_instr;
  logic src1_ready, src2_ready;
  logic rob_valid, rob_ready;
  logic rs_alu_valid, rs_alu_ready, rs_br_valid, rs_br_ready, rs_lsu_valid, rs_lsu_ready;
  logic wb_valid;
  logic [PHYS_REG_BITS-1:0] wb_prd;
  logic mispredict;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dispatch dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .renamed_instr(renamed_instr), .disp_instr(disp_instr),
    .src1_ready(src1_ready), .src2_ready(src2_ready),
    .rob_valid(rob_valid), .rob_ready(rob_ready),
    .rs_alu_valid(rs_alu_valid), .rs_alu_ready(rs_alu_ready),
    .rs_br_valid(rs_br_valid), .rs_br_ready(rs_br_ready),
    .rs_lsu_valid(rs_lsu_valid), .rs_lsu_ready(rs_lsu_ready),
    .wb_valid(wb_valid), .wb_prd(wb_prd), .mispredict(mispredict)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       vi;
    int       tag, fu, prd, p1, p2;
    bit       rw;
    bit       rob_r;
    bit [2:0] rdy;     // {lsu, br, alu}
    bit       wbv;
    int       wbp;
    bit       mp;
    bit       e_ro, e_rob;
    bit [2:0] e_rs;    // {lsu, br, alu}
    bit       cs, e_s1, e_s2;
    bit       ct;
    int       e_tag;
  } vec_t;

  function automatic vec_t mk(input bit vi, input int tag, input int fu, input bit rw,
                              input int prd, input int p1, input int p2,
                              input bit rob_r, input bit [2:0] rdy, input bit wbv,
                              input int wbp, input bit mp,
                              input bit e_ro, input bit e_rob, input bit [2:0] e_rs,
                              input bit cs, input bit e_s1, input bit e_s2,
                              input bit ct, input int e_tag);
    vec_t v;
    v.vi = vi; v.tag = tag; v.fu = fu; v.rw = rw; v.prd = prd; v.p1 = p1; v.p2 = p2;
    v.rob_r = rob_r; v.rdy = rdy; v.wbv = wbv; v.wbp = wbp; v.mp = mp;
    v.e_ro = e_ro; v.e_rob = e_rob; v.e_rs = e_rs;
    v.cs = cs; v.e_s1 = e_s1; v.e_s2 = e_s2; v.ct = ct; v.e_tag = e_tag;
    return v;
  endfunction

  task automatic drive(input bit vi, input int tag, input int fu, input bit rw,
                       input int prd, input int p1, input int p2);
    valid_in              = vi;
    renamed_instr         = '0;
    renamed_instr.pc      = 32'h1000 + 32'(tag) * 4;
    renamed_instr.rob_tag = ROB_BITS'(tag);
    renamed_instr.fu_type = 2'(fu);
    renamed_instr.reg_write = rw;
    renamed_instr.prd     = PHYS_REG_BITS'(prd);
    renamed_instr.prs1    = PHYS_REG_BITS'(p1);
    renamed_instr.prs2    = PHYS_REG_BITS'(p2);
  endtask

  task automatic idle_inputs();
    drive(0, 0, 0, 0, 0, 0, 0);
    rob_ready = 1; rs_alu_ready = 1; rs_br_ready = 1; rs_lsu_ready = 1;
    wb_valid = 0; wb_prd = '0; mispredict = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- reference model ----------------
  bit             pending [2**PHYS_REG_BITS];
  renamed_instr_t model_q[$];   // at most one entry: the instruction awaiting dispatch

  function automatic int station_of(input logic [1:0] fu);
    if (fu == 2'b01) return 1;
    if (fu == 2'b10) return 2;
    return 0;
  endfunction

  function automatic bit src_avail(input int p);
    return (p == 0) || !pending[p] || (wb_valid && int'(wb_prd) == p);
  endfunction

  vec_t vecs[28];

  initial begin
    rst = 1;
    idle_inputs();

    // --- reset state ---
    do_reset();
    #2;
    check("reset_ready_out", ready_out, 1);
    check("reset_rob_valid", rob_valid, 0);
    check("reset_rs_valids", {rs_lsu_valid, rs_br_valid, rs_alu_valid}, 0);

    //           vi tag fu rw prd p1 p2  rob rdy     wbv wbp mp  ro rob rs      cs s1 s2 ct tag
    vecs[0]  = mk(1, 0, 0, 1, 32, 2, 3,  1, 3'b111, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 1, 33, 32, 3, 1, 3'b111, 0, 0, 0,  1, 1, 3'b001, 1, 1, 1, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0,   1, 3'b111, 0, 0, 0,  1, 1, 3'b001, 1, 0, 1, 1, 1);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0,   1, 3'b111, 1, 32, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 2, 0, 1, 34, 32, 0, 1, 3'b111, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0,   1, 3'b111, 0, 0, 0,  1, 1, 3'b001, 1, 1, 1, 1, 2);
    // stall on ALU with a pending source, then wakeup in the release cycle
    vecs[6]  = mk(1, 3, 0, 1, 35, 33, 2, 1, 3'b110, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 4, 1, 1, 36, 2, 2,  1, 3'b110, 0, 0, 0,  0, 0, 3'b000, 1, 0, 1, 1, 3);
    vecs[8]  = mk(1, 4, 1, 1, 36, 2, 2,  1, 3'b111, 1, 33, 0, 1, 1, 3'b001, 1, 1, 1, 1, 3);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0,   1, 3'b111, 0, 0, 0,  1, 1, 3'b010, 1, 1, 1, 1, 4);
    // store to LSU, LSU full while ALU free
    vecs[10] = mk(1, 5, 2, 0, 37, 1, 1,  1, 3'b011, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0,   1, 3'b011, 0, 0, 0,  0, 0, 3'b000, 0, 0, 0, 1, 5);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0,   1, 3'b011, 0, 0, 0,  0, 0, 3'b000, 0, 0, 0, 1, 5);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0,   1, 3'b111, 0, 0, 0,  1, 1, 3'b100, 1, 1, 1, 1, 5);
    // ROB full; prs1=37 was a store destination so it was never marked busy
    vecs[14] = mk(1, 6, 0, 1, 0, 37, 0,  1, 3'b111, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0,   0, 3'b111, 0, 0, 0,  0, 0, 3'b000, 1, 1, 1, 1, 6);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0,   1, 3'b111, 0, 0, 0,  1, 1, 3'b001, 1, 1, 1, 1, 6);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0,   1, 3'b111, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0, 0);
    // back-to-back stream, tags 0..3
    vecs[18] = mk(1, 0, 0, 1, 40, 0, 0,  1, 3'b111, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 1, 0, 1, 41, 0, 0,  1, 3'b111, 0, 0, 0,  1, 1, 3'b001, 1, 1, 1, 1, 0);
    vecs[20] = mk(1, 2, 0, 1, 42, 0, 0,  1, 3'b111, 0, 0, 0,  1, 1, 3'b001, 1, 1, 1, 1, 1);
    vecs[21] = mk(1, 3, 0, 1, 43, 0, 0,  1, 3'b111, 0, 0, 0,  1, 1, 3'b001, 1, 1, 1, 1, 2);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0,   1, 3'b111, 0, 0, 0,  1, 1, 3'b001, 1, 1, 1, 1, 3);
    // mispredict while holding; the offered instruction is not accepted
    vecs[23] = mk(1, 7, 0, 1, 44, 0, 0,  1, 3'b111, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0, 0);
    vecs[24] = mk(1, 8, 0, 1, 45, 0, 0,  1, 3'b111, 0, 0, 1,  0, 0, 3'b000, 0, 0, 0, 1, 7);
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 0,   1, 3'b111, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0, 0);
    // neither squashed p44 nor never-accepted p45 became busy
    vecs[26] = mk(1, 10, 0, 1, 46, 45, 44, 1, 3'b111, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0);
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 0,   1, 3'b111, 0, 0, 0,  1, 1, 3'b001, 1, 1, 1, 1, 10);

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].vi, vecs[i].tag, vecs[i].fu, vecs[i].rw, vecs[i].prd, vecs[i].p1, vecs[i].p2);
      rob_ready    = vecs[i].rob_r;
      rs_alu_ready = vecs[i].rdy[0];
      rs_br_ready  = vecs[i].rdy[1];
      rs_lsu_ready = vecs[i].rdy[2];
      wb_valid     = vecs[i].wbv;
      wb_prd       = PHYS_REG_BITS'(vecs[i].wbp);
      mispredict   = vecs[i].mp;
      #2;
      check($sformatf("vec%0d ready_out", i), ready_out, vecs[i].e_ro);
      check($sformatf("vec%0d rob_valid", i), rob_valid, vecs[i].e_rob);
      check($sformatf("vec%0d rs_valids", i), {rs_lsu_valid, rs_br_valid, rs_alu_valid}, vecs[i].e_rs);
      if (vecs[i].cs) begin
        check($sformatf("vec%0d src1_ready", i), src1_ready, vecs[i].e_s1);
        check($sformatf("vec%0d src2_ready", i), src2_ready, vecs[i].e_s2);
      end
      if (vecs[i].ct)
        check($sformatf("vec%0d rob_tag", i), disp_instr.rob_tag, vecs[i].e_tag);
      @(negedge clk);
    end

    // --- reset in the middle of a stall ---
    // p34 and p40 are busy at this point (dispatched, no writeback).
    drive(1, 9, 0, 1, 50, 34, 40);
    rs_alu_ready = 0;
    #2;
    check("rst_stall accept", ready_out, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst_stall ready_out", ready_out, 0);
    check("rst_stall rob_valid", rob_valid, 0);
    check("rst_stall src1 busy", src1_ready, 0);
    @(negedge clk);
    rst = 1;
    rs_alu_ready = 1;
    @(negedge clk);
    rst = 0;
    #2;
    check("post_rst ready_out", ready_out, 1);
    check("post_rst rob_valid", rob_valid, 0);
    check("post_rst rs_alu_valid", rs_alu_valid, 0);
    @(negedge clk);
    drive(1, 9, 0, 1, 50, 34, 40);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("post_rst fire", rob_valid, 1);
    check("post_rst src1 cleared", src1_ready, 1);
    check("post_rst src2 cleared", src2_ready, 1);

    // --- randomized run against the reference model ---
    do_reset();
    foreach (pending[i]) pending[i] = 0;
    model_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit rs_rdy[3];
      bit have, fire, exp_ready;
      int st;
      renamed_instr_t h;

      valid_in              = ($urandom_range(0, 9) < 7);
      renamed_instr.pc      = $urandom;
      renamed_instr.rob_tag = ROB_BITS'($urandom);
      renamed_instr.fu_type = 2'($urandom);
      renamed_instr.reg_write = ($urandom_range(0, 3) != 0);
      renamed_instr.prd     = PHYS_REG_BITS'($urandom_range(0, 9));
      renamed_instr.prs1    = PHYS_REG_BITS'($urandom_range(0, 9));
      renamed_instr.prs2    = PHYS_REG_BITS'($urandom_range(0, 9));
      rob_ready    = ($urandom_range(0, 9) < 8);
      rs_alu_ready = ($urandom_range(0, 3) != 0);
      rs_br_ready  = ($urandom_range(0, 3) != 0);
      rs_lsu_ready = ($urandom_range(0, 3) != 0);
      wb_valid     = ($urandom_range(0, 9) < 4);
      wb_prd       = PHYS_REG_BITS'($urandom_range(0, 9));
      mispredict   = ($urandom_range(0, 19) == 0);
      #2;

      rs_rdy[0] = rs_alu_ready; rs_rdy[1] = rs_br_ready; rs_rdy[2] = rs_lsu_ready;
      have = (model_q.size() != 0);
      h    = have ? model_q[0] : '0;
      st   = station_of(h.fu_type);
      fire = have && rob_ready && rs_rdy[st] && !mispredict;
      exp_ready = !mispredict && (!have || fire);

      check("rnd ready_out", ready_out, exp_ready);
      check("rnd rob_valid", rob_valid, fire);
      check("rnd rs_valids", {rs_lsu_valid, rs_br_valid, rs_alu_valid},
            fire ? (3'b001 << st) : 3'b000);
      if (have) begin
        check("rnd disp_instr", disp_instr, h);
        check("rnd src1_ready", src1_ready, src_avail(int'(h.prs1)));
        check("rnd src2_ready", src2_ready, src_avail(int'(h.prs2)));
      end

      // advance model state for the coming edge
      if (wb_valid) pending[wb_prd] = 0;
      if (fire && h.reg_write && h.prd != 0) pending[h.prd] = 1;
      if (fire) void'(model_q.pop_front());
      if (valid_in && exp_ready) model_q.push_back(renamed_instr);
      if (mispredict) model_q.delete();

      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
